// File: rtl/sayeh_controller.sv
// sayeh_controller: multi-cycle control unit for the SAYEH CPU.
// Sequences fetch / decode / execute / memory-wait / PC-increment and drives
// every datapath control strobe from the state, the IR contents, the flags
// and the memory ready handshake.
// Ports:
//   clk, ExternalReset (sync, active high)
//   Instruction[15:0]  IR contents; Cout, Zout flags; MemDataReady handshake
//   outputs: bus strobes, addressing-unit selects, ALU one-hot select,
//            register-file / WP / IR / SR loads, bus drivers, flag controls
module sayeh_controller (
    input  logic        clk,
    input  logic        ExternalReset,
    input  logic [15:0] Instruction,
    input  logic        Cout,
    input  logic        Zout,
    input  logic        MemDataReady,
    output logic        ReadMem, WriteMem, ReadIO, WriteIO,
    output logic        ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC,
    output logic        Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide,
    output logic        B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB,
    output logic        RFLwrite, RFHwrite,
    output logic        WPreset, WPadd, IRload, SRload,
    output logic        Address_on_Databus, ALU_on_Databus, IR_on_LOpndBus, IR_on_HOpndBus,
    output logic        RFright_on_OpndBus,
    output logic        Cset, Creset, Zset, Zreset, Shadow
);

    typedef enum logic [2:0] {
        S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEMWAIT, S_INCPC, S_HALT
    } state_t;

    state_t state;
    logic   shadow_q;   // executing the low (shadow) byte of a short pair

    // In the shadow byte the low 8 bits carry the opcode/sub fields.
    logic [3:0] op, sub;
    logic       is_load, is_store, is_mem, is_long, is_hlt, jump_taken, has_shadow;

    assign op         = shadow_q ? Instruction[7:4] : Instruction[15:12];
    assign sub        = shadow_q ? Instruction[3:0] : Instruction[11:8];
    assign is_load    = (op == 4'h2) || (op == 4'h4);
    assign is_store   = (op == 4'h3) || (op == 4'h5);
    assign is_mem     = is_load || is_store;
    // A 1111 nibble in the shadow byte has no meaning and executes as nop.
    assign is_long    = (op == 4'hF) && !shadow_q;
    assign is_hlt     = (op == 4'h0) && (sub == 4'h1);
    // Branches in the shadow byte are ignored.
    assign jump_taken = (!shadow_q && op == 4'h0 &&
                         (sub == 4'h7 || (sub == 4'h8 && Zout) || (sub == 4'h9 && Cout)))
                      || (is_long && sub[1:0] == 2'b11);
    assign has_shadow = !shadow_q && !is_long && (Instruction[7:0] != 8'h00);

    always_ff @(posedge clk) begin
        if (ExternalReset) begin
            state    <= S_RESET;
            shadow_q <= 1'b0;
        end else begin
            case (state)
                S_RESET:  state <= S_FETCH;
                S_FETCH:  if (MemDataReady) state <= S_DECODE;
                S_DECODE: begin
                    state    <= S_EXEC;
                    shadow_q <= 1'b0;
                end
                S_EXEC: begin
                    if (is_hlt)          state <= S_HALT;
                    else if (jump_taken) state <= S_FETCH;
                    else if (is_mem)     state <= S_MEMWAIT;
                    else if (has_shadow) begin
                        state    <= S_EXEC;
                        shadow_q <= 1'b1;
                    end else             state <= S_INCPC;
                end
                S_MEMWAIT: begin
                    if (MemDataReady) begin
                        if (has_shadow) begin
                            state    <= S_EXEC;
                            shadow_q <= 1'b1;
                        end else state <= S_INCPC;
                    end
                end
                S_INCPC:  state <= S_FETCH;
                S_HALT:   state <= S_HALT;
                default:  state <= S_RESET;
            endcase
        end
    end

    always_comb begin
        {ReadMem, WriteMem, ReadIO, WriteIO} = '0;
        {ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC} = '0;
        {Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide} = '0;
        {B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB} = '0;
        {RFLwrite, RFHwrite, WPreset, WPadd, IRload, SRload} = '0;
        {Address_on_Databus, ALU_on_Databus, IR_on_LOpndBus, IR_on_HOpndBus} = '0;
        RFright_on_OpndBus = 1'b0;
        {Cset, Creset, Zset, Zreset, Shadow} = '0;

        case (state)
            S_RESET: begin
                ResetPC  = 1'b1;
                EnablePC = 1'b1;
                WPreset  = 1'b1;
            end
            S_FETCH: begin
                ReadMem = 1'b1;
                IRload  = MemDataReady;
            end
            S_INCPC: begin
                PCplus1  = 1'b1;
                EnablePC = 1'b1;
            end
            S_EXEC, S_MEMWAIT: begin
                Shadow = shadow_q;
                if (is_mem) begin
                    // MEMWAIT repeats the EXEC address/strobe/data controls so
                    // the transfer stays stable until ready.
                    Rplus0 = 1'b1;
                    if (is_load) begin
                        Rs_on_AddressUnitRSide = 1'b1;
                        ReadMem  = (op == 4'h2);
                        ReadIO   = (op == 4'h4);
                        RFLwrite = (state == S_MEMWAIT) && MemDataReady;
                        RFHwrite = (state == S_MEMWAIT) && MemDataReady;
                    end else begin
                        Rd_on_AddressUnitRSide = 1'b1;
                        RFright_on_OpndBus     = 1'b1;
                        B15to0                 = 1'b1;
                        ALU_on_Databus         = 1'b1;
                        WriteMem = (op == 4'h3);
                        WriteIO  = (op == 4'h5);
                    end
                end else if (state == S_EXEC) begin
                    case (op)
                        4'h0: begin
                            case (sub)
                                4'h2: Zset    = 1'b1;
                                4'h3: Zreset  = 1'b1;
                                4'h4: Cset    = 1'b1;
                                4'h5: Creset  = 1'b1;
                                4'h6: WPreset = 1'b1;
                                4'hA: WPadd   = 1'b1;
                                default: ;
                            endcase
                            if (jump_taken) begin
                                PCplusI  = 1'b1;
                                EnablePC = 1'b1;
                            end
                        end
                        4'h1: begin
                            RFright_on_OpndBus = 1'b1;
                            B15to0             = 1'b1;
                            ALU_on_Databus     = 1'b1;
                            RFLwrite           = 1'b1;
                            RFHwrite           = 1'b1;
                        end
                        4'hE: begin
                            RFright_on_OpndBus = 1'b1;
                            AcmpB              = 1'b1;
                            SRload             = 1'b1;
                        end
                        4'hF: begin
                            if (!shadow_q) begin
                                case (sub[1:0])
                                    2'b00: begin
                                        IR_on_LOpndBus = 1'b1;
                                        B15to0         = 1'b1;
                                        ALU_on_Databus = 1'b1;
                                        RFLwrite       = 1'b1;
                                    end
                                    2'b01: begin
                                        IR_on_HOpndBus = 1'b1;
                                        B15to0         = 1'b1;
                                        ALU_on_Databus = 1'b1;
                                        RFHwrite       = 1'b1;
                                    end
                                    2'b10: begin
                                        // PC+I is computed on the address unit but
                                        // only routed to the RF; PC itself holds.
                                        PCplusI            = 1'b1;
                                        Address_on_Databus = 1'b1;
                                        RFLwrite           = 1'b1;
                                        RFHwrite           = 1'b1;
                                    end
                                    default: begin
                                        Rd_on_AddressUnitRSide = 1'b1;
                                        RplusI                 = 1'b1;
                                        EnablePC               = 1'b1;
                                    end
                                endcase
                            end
                        end
                        default: begin
                            // 0110..1101: two-operand ALU ops writing Rd and SR
                            RFright_on_OpndBus = 1'b1;
                            ALU_on_Databus     = 1'b1;
                            RFLwrite           = 1'b1;
                            RFHwrite           = 1'b1;
                            SRload             = 1'b1;
                            case (op)
                                4'h6:    AandB = 1'b1;
                                4'h7:    AorB  = 1'b1;
                                4'h8:    notB  = 1'b1;
                                4'h9:    shlB  = 1'b1;
                                4'hA:    shrB  = 1'b1;
                                4'hB:    AaddB = 1'b1;
                                4'hC:    AsubB = 1'b1;
                                default: AmulB = 1'b1;
                            endcase
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sayeh_controller.sv
// Directed bench for sayeh_controller: a table of single instructions traced
// from FETCH to the next FETCH, plus hand sequences for stalls, halt and reset.
module tb_sayeh_controller;

    logic        clk = 1'b0;
    logic        ExternalReset;
    logic [15:0] Instruction;
    logic        Cout, Zout, MemDataReady;
    logic ReadMem, WriteMem, ReadIO, WriteIO;
    logic ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC;
    logic Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide;
    logic B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB;
    logic RFLwrite, RFHwrite, WPreset, WPadd, IRload, SRload;
    logic Address_on_Databus, ALU_on_Databus, IR_on_LOpndBus, IR_on_HOpndBus;
    logic RFright_on_OpndBus, Cset, Creset, Zset, Zreset, Shadow;

    always #5 clk = ~clk;

    sayeh_controller dut (
        .clk(clk), .ExternalReset(ExternalReset), .Instruction(Instruction),
        .Cout(Cout), .Zout(Zout), .MemDataReady(MemDataReady),
        .ReadMem(ReadMem), .WriteMem(WriteMem), .ReadIO(ReadIO), .WriteIO(WriteIO),
        .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1), .RplusI(RplusI),
        .Rplus0(Rplus0), .EnablePC(EnablePC),
        .Rs_on_AddressUnitRSide(Rs_on_AddressUnitRSide),
        .Rd_on_AddressUnitRSide(Rd_on_AddressUnitRSide),
        .B15to0(B15to0), .AandB(AandB), .AorB(AorB), .notB(notB), .shlB(shlB),
        .shrB(shrB), .AaddB(AaddB), .AsubB(AsubB), .AmulB(AmulB), .AcmpB(AcmpB),
        .RFLwrite(RFLwrite), .RFHwrite(RFHwrite), .WPreset(WPreset), .WPadd(WPadd),
        .IRload(IRload), .SRload(SRload), .Address_on_Databus(Address_on_Databus),
        .ALU_on_Databus(ALU_on_Databus), .IR_on_LOpndBus(IR_on_LOpndBus),
        .IR_on_HOpndBus(IR_on_HOpndBus), .RFright_on_OpndBus(RFright_on_OpndBus),
        .Cset(Cset), .Creset(Creset), .Zset(Zset), .Zreset(Zreset), .Shadow(Shadow)
    );

    // All outputs packed; bit n matches the M_* masks below.
    logic [37:0] vec;
    assign vec = {Shadow, Zreset, Zset, Creset, Cset, RFright_on_OpndBus,
                  IR_on_HOpndBus, IR_on_LOpndBus, ALU_on_Databus, Address_on_Databus,
                  SRload, IRload, WPadd, WPreset, RFHwrite, RFLwrite,
                  AcmpB, AmulB, AsubB, AaddB, shrB, shlB, notB, AorB, AandB, B15to0,
                  Rd_on_AddressUnitRSide, Rs_on_AddressUnitRSide,
                  EnablePC, Rplus0, RplusI, PCplus1, PCplusI, ResetPC,
                  WriteIO, ReadIO, WriteMem, ReadMem};

    localparam logic [37:0] M_RM  = 38'd1 << 0,  M_WM  = 38'd1 << 1,  M_RIO = 38'd1 << 2;
    localparam logic [37:0] M_WIO = 38'd1 << 3,  M_RPC = 38'd1 << 4,  M_PCPI = 38'd1 << 5;
    localparam logic [37:0] M_PCP1 = 38'd1 << 6, M_RPI = 38'd1 << 7,  M_RP0 = 38'd1 << 8;
    localparam logic [37:0] M_EPC = 38'd1 << 9,  M_RSR = 38'd1 << 10, M_RDR = 38'd1 << 11;
    localparam logic [37:0] M_B15 = 38'd1 << 12, M_AND = 38'd1 << 13, M_OR  = 38'd1 << 14;
    localparam logic [37:0] M_NOT = 38'd1 << 15, M_SHL = 38'd1 << 16, M_SHR = 38'd1 << 17;
    localparam logic [37:0] M_ADD = 38'd1 << 18, M_SUB = 38'd1 << 19, M_MUL = 38'd1 << 20;
    localparam logic [37:0] M_CMP = 38'd1 << 21, M_RFL = 38'd1 << 22, M_RFH = 38'd1 << 23;
    localparam logic [37:0] M_WPR = 38'd1 << 24, M_WPA = 38'd1 << 25, M_IRL = 38'd1 << 26;
    localparam logic [37:0] M_SRL = 38'd1 << 27, M_ADB = 38'd1 << 28, M_ALUD = 38'd1 << 29;
    localparam logic [37:0] M_IRLO = 38'd1 << 30, M_IRHO = 38'd1 << 31, M_RFR = 38'd1 << 32;
    localparam logic [37:0] M_CS  = 38'd1 << 33, M_CR  = 38'd1 << 34, M_ZS  = 38'd1 << 35;
    localparam logic [37:0] M_ZR  = 38'd1 << 36, M_SHD = 38'd1 << 37;

    localparam logic [37:0] V_RST   = M_RPC | M_EPC | M_WPR;
    localparam logic [37:0] V_FETCH = M_RM | M_IRL;
    localparam logic [37:0] V_INC   = M_PCP1 | M_EPC;
    localparam logic [37:0] V_ALU   = M_RFR | M_ALUD | M_RFL | M_RFH | M_SRL;
    localparam logic [37:0] V_ST    = M_RDR | M_RP0 | M_RFR | M_B15 | M_ALUD;

    typedef struct {
        logic [15:0] ir;
        logic        z;
        logic        c;
        int          cyc;   // FETCH to next FETCH
        logic [37:0] v2;    // third cycle (first EXEC)
        logic [37:0] v3;    // fourth cycle
    } vec_t;

    vec_t tbl[$];
    int   npass = 0, ntot = 0;
    logic [37:0] trace [0:15];
    int   ncyc;

    task automatic chk(input string name, input logic [37:0] act, input logic [37:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Entered at the #1-after-negedge point of a FETCH cycle; returns at the
    // same point of the next FETCH cycle.
    task automatic run_instr(input logic [15:0] ir, input logic z, input logic c);
        Instruction = ir; Zout = z; Cout = c; MemDataReady = 1'b1;
        #1;
        trace[0] = vec;
        ncyc = 0;
        for (int n = 1; n < 16; n++) begin
            @(negedge clk); #1;
            trace[n] = vec;
            if (vec[26]) begin ncyc = n; break; end
        end
    endtask

    task automatic step; @(negedge clk); #1; endtask

    initial begin
        tbl.push_back('{16'hB600, 0, 0, 4, V_ALU | M_ADD, V_INC});
        tbl.push_back('{16'h6600, 0, 0, 4, V_ALU | M_AND, V_INC});
        tbl.push_back('{16'h7600, 0, 0, 4, V_ALU | M_OR,  V_INC});
        tbl.push_back('{16'h8600, 0, 0, 4, V_ALU | M_NOT, V_INC});
        tbl.push_back('{16'h9600, 0, 0, 4, V_ALU | M_SHL, V_INC});
        tbl.push_back('{16'hA600, 0, 0, 4, V_ALU | M_SHR, V_INC});
        tbl.push_back('{16'hC100, 0, 0, 4, V_ALU | M_SUB, V_INC});
        tbl.push_back('{16'hD600, 0, 0, 4, V_ALU | M_MUL, V_INC});
        tbl.push_back('{16'h1600, 0, 0, 4, M_RFR | M_B15 | M_ALUD | M_RFL | M_RFH, V_INC});
        tbl.push_back('{16'hE600, 0, 0, 4, M_RFR | M_CMP | M_SRL, V_INC});
        tbl.push_back('{16'h2600, 0, 0, 5, M_RSR | M_RP0 | M_RM, M_RSR | M_RP0 | M_RM | M_RFL | M_RFH});
        tbl.push_back('{16'h3600, 0, 0, 5, V_ST | M_WM, V_ST | M_WM});
        tbl.push_back('{16'h4600, 0, 0, 5, M_RSR | M_RP0 | M_RIO, M_RSR | M_RP0 | M_RIO | M_RFL | M_RFH});
        tbl.push_back('{16'h5600, 0, 0, 5, V_ST | M_WIO, V_ST | M_WIO});
        tbl.push_back('{16'hF412, 0, 0, 4, M_IRLO | M_B15 | M_ALUD | M_RFL, V_INC});
        tbl.push_back('{16'hF512, 0, 0, 4, M_IRHO | M_B15 | M_ALUD | M_RFH, V_INC});
        tbl.push_back('{16'hF612, 0, 0, 4, M_PCPI | M_ADB | M_RFL | M_RFH, V_INC});
        tbl.push_back('{16'hF700, 0, 0, 3, M_RDR | M_RPI | M_EPC, V_FETCH});
        tbl.push_back('{16'h0800, 1, 0, 3, M_PCPI | M_EPC, V_FETCH});
        tbl.push_back('{16'h0800, 0, 1, 4, 38'd0, V_INC});
        tbl.push_back('{16'h0900, 0, 1, 3, M_PCPI | M_EPC, V_FETCH});
        tbl.push_back('{16'h0900, 1, 0, 4, 38'd0, V_INC});
        tbl.push_back('{16'h0206, 0, 0, 5, M_ZS, M_WPR | M_SHD});
        tbl.push_back('{16'h0200, 0, 0, 4, M_ZS, V_INC});
        tbl.push_back('{16'h0005, 0, 0, 5, 38'd0, M_CR | M_SHD});
        tbl.push_back('{16'h0A00, 0, 0, 4, M_WPA, V_INC});
        tbl.push_back('{16'h0400, 0, 0, 4, M_CS, V_INC});
        tbl.push_back('{16'h0780, 0, 0, 3, M_PCPI | M_EPC, V_FETCH});
        tbl.push_back('{16'h0307, 0, 0, 5, M_ZR, M_SHD});
        tbl.push_back('{16'h0008, 1, 0, 5, 38'd0, M_SHD});
        tbl.push_back('{16'h0026, 0, 0, 6, 38'd0, M_RSR | M_RP0 | M_RM | M_SHD});
        tbl.push_back('{16'h0035, 0, 0, 6, 38'd0, V_ST | M_WM | M_SHD});

        // Reset held two cycles, then released.
        Instruction = 16'h0000; Zout = 0; Cout = 0; MemDataReady = 0;
        ExternalReset = 1'b1;
        step; step;
        chk("reset_hold", vec, V_RST);
        ExternalReset = 1'b0; #1;
        chk("reset_release", vec, V_RST);
        step;
        chk("first_fetch_stall", vec, M_RM);
        step;
        chk("fetch_still_stall", vec, M_RM);

        foreach (tbl[i]) begin
            run_instr(tbl[i].ir, tbl[i].z, tbl[i].c);
            chk_int($sformatf("cycles_%h_z%0d_c%0d", tbl[i].ir, tbl[i].z, tbl[i].c), ncyc, tbl[i].cyc);
            chk($sformatf("exec_%h_z%0d_c%0d", tbl[i].ir, tbl[i].z, tbl[i].c), trace[2], tbl[i].v2);
            chk($sformatf("cyc3_%h_z%0d_c%0d", tbl[i].ir, tbl[i].z, tbl[i].c), trace[3], tbl[i].v3);
        end

        // lda with ready arriving in the third MEMWAIT cycle.
        Instruction = 16'h2600; MemDataReady = 1'b1; #1;
        chk("lda_fetch", vec, V_FETCH);
        step; MemDataReady = 1'b0; #1;
        chk("lda_decode", vec, 38'd0);
        step; chk("lda_exec", vec, M_RSR | M_RP0 | M_RM);
        step; chk("lda_wait1", vec, M_RSR | M_RP0 | M_RM);
        step; chk("lda_wait2", vec, M_RSR | M_RP0 | M_RM);
        step; MemDataReady = 1'b1; #1;
        chk("lda_ready", vec, M_RSR | M_RP0 | M_RM | M_RFL | M_RFH);
        step; chk("lda_incpc", vec, V_INC);
        step; chk("lda_next_fetch", vec, V_FETCH);

        // hlt: everything quiet regardless of ready.
        Instruction = 16'h0100; #1;
        step; step; chk("hlt_exec", vec, 38'd0);
        for (int k = 0; k < 4; k++) begin
            MemDataReady = k[0];
            step; chk($sformatf("halt_%0d", k), vec, 38'd0);
        end
        ExternalReset = 1'b1;
        step; chk("halt_reset", vec, V_RST);
        ExternalReset = 1'b0;
        MemDataReady = 1'b1;
        step; chk("after_halt_fetch", vec, V_FETCH);

        // sta with reset asserted in MEMWAIT.
        Instruction = 16'h3600; #1;
        step; MemDataReady = 1'b0; #1;
        step; chk("sta_exec", vec, V_ST | M_WM);
        step; chk("sta_wait", vec, V_ST | M_WM);
        ExternalReset = 1'b1; #1;
        chk("sta_wait_rst_same_cycle", vec, V_ST | M_WM);
        step; chk("sta_reset_drops_wm", vec, V_RST);
        ExternalReset = 1'b0;
        step; chk("sta_reset_refetch", vec, M_RM);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
